// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC-source sequencer: FSM states, request kinds,
// PC mux select codes and exception vector constants.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_EXC_SAVE = 3'd2,
    ST_EXC_WAIT = 3'd3,
    ST_EXC_LOAD = 3'd4
  } state_t;

  localparam logic [2:0] KIND_SEQ    = 3'b000;
  localparam logic [2:0] KIND_BRANCH = 3'b001;
  localparam logic [2:0] KIND_JUMP   = 3'b010;
  localparam logic [2:0] KIND_JR     = 3'b011;
  localparam logic [2:0] KIND_RTE    = 3'b100;
  localparam logic [2:0] KIND_EXC    = 3'b101;

  localparam logic [2:0] SEL_ALU_OUT    = 3'b000;
  localparam logic [2:0] SEL_ALU_RESULT = 3'b001;
  localparam logic [2:0] SEL_JUMP       = 3'b010;
  localparam logic [2:0] SEL_EPC        = 3'b011;
  localparam logic [2:0] SEL_MDR        = 3'b100;

  localparam logic [1:0] EXC_INVALID_OP = 2'd0;
  localparam logic [1:0] EXC_OVERFLOW   = 2'd1;
  localparam logic [1:0] EXC_DIV_ZERO   = 2'd2;
  localparam logic [1:0] EXC_RESERVED   = 2'd3;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'd253;

  // The reserved exception code shares the invalid-opcode vector.
  function automatic logic [1:0] vec_code(input logic [1:0] code);
    return (code == EXC_RESERVED) ? EXC_INVALID_OP : code;
  endfunction

endpackage

// File: rtl/pc_src_sequencer_lat_counter.sv
// 3-bit loadable down-counter with zero flag; times the exception vector fetch.
module lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/pc_src_sequencer.sv
// Sequences every PC update (fetch, branch, jumps, RTE) and the multi-cycle
// exception entry: save EPC, fetch handler vector, load it into PC.
module pc_src_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_kind,
  input  logic        branch_taken,
  input  logic [1:0]  exc_code,
  output logic        req_ready,
  output logic [2:0]  seletor,
  output logic        pc_write,
  output logic        epc_write,
  output logic        mem_read,
  output logic [31:0] vec_addr,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  kind_q, kind_d;
  logic        taken_q, taken_d;
  logic [1:0]  code_q, code_d;
  logic        cnt_load, cnt_en, cnt_zero;

  logic [2:0]  seletor_q, seletor_d;
  logic        pc_write_q, pc_write_d;
  logic        epc_write_q, epc_write_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] vec_addr_q, vec_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  // Next-state logic and request field capture.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    taken_d  = taken_q;
    code_d   = code_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          kind_d  = req_kind;
          taken_d = branch_taken;
          code_d  = exc_code;
          state_d = (req_kind == KIND_EXC) ? ST_EXC_SAVE : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC:     state_d = ST_IDLE;
      ST_EXC_SAVE: begin
        cnt_load = 1'b1;
        state_d  = ST_EXC_WAIT;
      end
      ST_EXC_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_EXC_LOAD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_EXC_LOAD: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    seletor_d   = SEL_ALU_RESULT;
    pc_write_d  = 1'b0;
    epc_write_d = 1'b0;
    mem_read_d  = 1'b0;
    vec_addr_d  = 32'd0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = 1'b0;
    case (state_d)
      ST_EXEC: begin
        done_d = 1'b1;
        case (kind_d)
          KIND_SEQ, KIND_JR: pc_write_d = 1'b1;
          KIND_BRANCH: begin
            seletor_d  = SEL_ALU_OUT;
            pc_write_d = taken_d;
          end
          KIND_JUMP: begin
            seletor_d  = SEL_JUMP;
            pc_write_d = 1'b1;
          end
          KIND_RTE: begin
            seletor_d  = SEL_EPC;
            pc_write_d = 1'b1;
          end
          default: pc_write_d = 1'b0;
        endcase
      end
      ST_EXC_SAVE, ST_EXC_WAIT: begin
        epc_write_d = (state_d == ST_EXC_SAVE);
        mem_read_d  = 1'b1;
        vec_addr_d  = VEC_BASE + {30'd0, vec_code(code_d)};
      end
      ST_EXC_LOAD: begin
        seletor_d  = SEL_MDR;
        pc_write_d = 1'b1;
        done_d     = 1'b1;
      end
      default: seletor_d = SEL_ALU_RESULT;
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_SEQ;
      taken_q     <= 1'b0;
      code_q      <= EXC_INVALID_OP;
      seletor_q   <= SEL_ALU_RESULT;
      pc_write_q  <= 1'b0;
      epc_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      vec_addr_q  <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      taken_q     <= taken_d;
      code_q      <= code_d;
      seletor_q   <= seletor_d;
      pc_write_q  <= pc_write_d;
      epc_write_q <= epc_write_d;
      mem_read_q  <= mem_read_d;
      vec_addr_q  <= vec_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seletor   = seletor_q;
  assign pc_write  = pc_write_q;
  assign epc_write = epc_write_q;
  assign mem_read  = mem_read_q;
  assign vec_addr  = vec_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = !busy_q;

endmodule

// File: tb/tb_pc_src_sequencer.sv
// Directed bench for pc_src_sequencer: two instances (MEM_LAT 1 and 3) share
// clock, reset and request fields but have separate req_valid lines.
module tb_pc_src_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid1, valid3;
  logic [2:0]  kind;
  logic        taken;
  logic [1:0]  code;

  logic        rdy1, pw1, epc1, mem1, busy1, done1;
  logic [2:0]  sel1;
  logic [31:0] vec1;
  logic        rdy3, pw3, epc3, mem3, busy3, done3;
  logic [2:0]  sel3;
  logic [31:0] vec3;

  logic [8:0] obs1, obs3;
  assign obs1 = {sel1, pw1, epc1, mem1, done1, busy1, rdy1};
  assign obs3 = {sel3, pw3, epc3, mem3, done3, busy3, rdy3};

  // {seletor, pc_write, epc_write, mem_read, done, busy, req_ready}
  localparam logic [8:0] E_IDLE  = {3'b001, 6'b000001};
  localparam logic [8:0] E_SEQ   = {3'b001, 6'b100110};
  localparam logic [8:0] E_BR_NT = {3'b000, 6'b000110};
  localparam logic [8:0] E_BR_T  = {3'b000, 6'b100110};
  localparam logic [8:0] E_JUMP  = {3'b010, 6'b100110};
  localparam logic [8:0] E_RTE   = {3'b011, 6'b100110};
  localparam logic [8:0] E_RSV   = {3'b001, 6'b000110};
  localparam logic [8:0] E_SAVE  = {3'b001, 6'b011010};
  localparam logic [8:0] E_WAIT  = {3'b001, 6'b001010};
  localparam logic [8:0] E_LOAD  = {3'b100, 6'b100110};

  int n_checks = 0;
  int n_pass   = 0;

  pc_src_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_kind(kind),
    .branch_taken(taken), .exc_code(code), .req_ready(rdy1), .seletor(sel1),
    .pc_write(pw1), .epc_write(epc1), .mem_read(mem1), .vec_addr(vec1),
    .busy(busy1), .done(done1)
  );

  pc_src_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(valid3), .req_kind(kind),
    .branch_taken(taken), .exc_code(code), .req_ready(rdy3), .seletor(sel3),
    .pc_write(pw3), .epc_write(epc3), .mem_read(mem3), .vec_addr(vec3),
    .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid1 = 1'b1; valid3 = 1'b1; kind = 3'b000; taken = 1'b0; code = 2'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs1 !== E_IDLE || vec1 !== 32'd0) $display("FAIL reset_dut1 cyc%0d: got %b vec %0d, want %b vec 0", i, obs1, vec1, E_IDLE);
      else n_pass++;
      n_checks++;
      if (obs3 !== E_IDLE || vec3 !== 32'd0) $display("FAIL reset_dut3 cyc%0d: got %b vec %0d, want %b vec 0", i, obs3, vec3, E_IDLE);
      else n_pass++;
    end
    reset = 1'b0; valid3 = 1'b0;
    step();
    n_checks++;
    if (obs1 !== E_SEQ) $display("FAIL seq_after_reset: got %b, want %b", obs1, E_SEQ);
    else n_pass++;
    valid1 = 1'b0;
    step();
    n_checks++;
    if (obs1 !== E_IDLE) $display("FAIL seq_return_idle: got %b, want %b", obs1, E_IDLE);
    else n_pass++;
  endtask

  task automatic test_branch();
    logic [8:0] exp_v;
    for (int t = 0; t < 2; t++) begin
      valid1 = 1'b1; kind = 3'b001; taken = (t == 1);
      exp_v = (t == 1) ? E_BR_T : E_BR_NT;
      step();
      valid1 = 1'b0; taken = 1'b0;
      n_checks++;
      if (obs1 !== exp_v) $display("FAIL branch_taken%0d: got %b, want %b", t, obs1, exp_v);
      else n_pass++;
      step();
      n_checks++;
      if (obs1 !== E_IDLE) $display("FAIL branch_idle%0d: got %b, want %b", t, obs1, E_IDLE);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] kinds [3];
    logic [8:0] exps  [3];
    kinds[0] = 3'b010; kinds[1] = 3'b011; kinds[2] = 3'b100;
    exps[0]  = E_JUMP; exps[1]  = E_SEQ;  exps[2]  = E_RTE;
    valid1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kind = kinds[i];
      step();
      n_checks++;
      if (obs1 !== exps[i]) $display("FAIL b2b_exec%0d: got %b, want %b", i, obs1, exps[i]);
      else n_pass++;
      // Present a different request while busy; it must be dropped.
      kind = (i < 2) ? kinds[i+1] : 3'b101;
      if (i == 2) valid1 = 1'b0;
      step();
      n_checks++;
      if (obs1 !== E_IDLE) $display("FAIL b2b_ignored%0d: got %b, want %b", i, obs1, E_IDLE);
      else n_pass++;
    end
  endtask

  task automatic test_exc_lat1();
    valid1 = 1'b1; kind = 3'b101; code = 2'd1;
    step();
    valid1 = 1'b0; kind = 3'b000;
    n_checks++;
    if (obs1 !== E_SAVE || vec1 !== 32'd254) $display("FAIL exc1_save: got %b vec %0d, want %b vec 254", obs1, vec1, E_SAVE);
    else n_pass++;
    step();
    n_checks++;
    if (obs1 !== E_WAIT || vec1 !== 32'd254) $display("FAIL exc1_wait: got %b vec %0d, want %b vec 254", obs1, vec1, E_WAIT);
    else n_pass++;
    step();
    n_checks++;
    if (obs1 !== E_LOAD) $display("FAIL exc1_load: got %b, want %b", obs1, E_LOAD);
    else n_pass++;
    // A request arriving while done is high is not accepted.
    valid1 = 1'b1; kind = 3'b010;
    step();
    n_checks++;
    if (obs1 !== E_IDLE) $display("FAIL exc1_done_req_ignored: got %b, want %b", obs1, E_IDLE);
    else n_pass++;
    step();
    valid1 = 1'b0;
    n_checks++;
    if (obs1 !== E_JUMP) $display("FAIL exc1_req_after_done: got %b, want %b", obs1, E_JUMP);
    else n_pass++;
    step();
  endtask

  task automatic test_exc_lat3();
    logic [8:0] exp_v;
    valid3 = 1'b1; kind = 3'b101; code = 2'd2;
    for (int c = 1; c <= 6; c++) begin
      step();
      valid3 = 1'b0;
      exp_v = (c == 1) ? E_SAVE : (c <= 4) ? E_WAIT : (c == 5) ? E_LOAD : E_IDLE;
      n_checks++;
      if (obs3 !== exp_v) $display("FAIL exc3_cyc%0d: got %b, want %b", c, obs3, exp_v);
      else n_pass++;
      if (c <= 4) begin
        n_checks++;
        if (vec3 !== 32'd255) $display("FAIL exc3_vec_cyc%0d: got %0d, want 255", c, vec3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_exc_code3_and_reserved();
    valid1 = 1'b1; kind = 3'b101; code = 2'd3;
    step();
    valid1 = 1'b0;
    n_checks++;
    if (obs1 !== E_SAVE || vec1 !== 32'd253) $display("FAIL exc_code3: got %b vec %0d, want %b vec 253", obs1, vec1, E_SAVE);
    else n_pass++;
    step(); step(); step();
    valid1 = 1'b1; kind = 3'b110;
    step();
    valid1 = 1'b0;
    n_checks++;
    if (obs1 !== E_RSV) $display("FAIL reserved_kind: got %b, want %b", obs1, E_RSV);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_exc();
    valid3 = 1'b1; kind = 3'b101; code = 2'd1;
    step();
    valid3 = 1'b0;
    step(); step();
    n_checks++;
    if (obs3 !== E_WAIT) $display("FAIL midreset_in_wait: got %b, want %b", obs3, E_WAIT);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (obs3 !== E_IDLE || vec3 !== 32'd0) $display("FAIL midreset_idle: got %b vec %0d, want %b vec 0", obs3, vec3, E_IDLE);
    else n_pass++;
    step();
    n_checks++;
    if (obs3 !== E_IDLE) $display("FAIL midreset_no_resume: got %b, want %b", obs3, E_IDLE);
    else n_pass++;
    valid3 = 1'b1; kind = 3'b000;
    step();
    valid3 = 1'b0;
    n_checks++;
    if (obs3 !== E_SEQ) $display("FAIL midreset_seq: got %b, want %b", obs3, E_SEQ);
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_back_to_back();
    test_exc_lat1();
    test_exc_lat3();
    test_exc_code3_and_reserved();
    test_reset_mid_exc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_src_sequencer.md
# pc_src_sequencer

Control block that drives the PC-source multiplexer of the multicycle datapath and sequences every PC update: sequential fetch, branch, jump, jump-register, return-from-exception, and the multi-cycle exception entry that saves EPC, reads the handler vector from memory and loads it into PC. It sits between the main control FSM, which issues one PC-update request per instruction phase, and the PC/EPC registers, memory read port and mux selector.

## Interface
Parameters:
- MEM_LAT, default 1: memory read latency in cycles, from mem_read asserted to vector valid on mdr; legal range 1–7.
- VEC_BASE, default 253: byte address of the first exception vector.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  PC-update request from main control.
- req_kind  in  3  000 SEQ, 001 BRANCH, 010 JUMP, 011 JR, 100 RTE, 101 EXC, 110/111 reserved.
- branch_taken  in  1  branch condition; sampled with the request.
- exc_code  in  2  0 invalid opcode, 1 overflow, 2 divide-by-zero, 3 reserved; sampled with the request.
- req_ready  out  1  high when a request can be accepted (IDLE only).
- seletor  out  3  mux select: 000 aluOut, 001 aluResult, 010 jump target, 011 EPC, 100 mdr.
- pc_write  out  1  PC load enable.
- epc_write  out  1  EPC load enable.
- mem_read  out  1  memory read strobe for vector fetch.
- vec_addr  out  32  vector address, valid while mem_read is high.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a request completes.

## Operation
- States: IDLE, EXEC, EXC_SAVE, EXC_WAIT, EXC_LOAD.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. req_kind, branch_taken and exc_code are latched on acceptance. req_valid while busy is ignored and not queued.
- IDLE: seletor=001, all strobes low.
- EXEC, one cycle, then IDLE:
  - SEQ: seletor=001, pc_write=1.
  - BRANCH: seletor=000, pc_write=latched branch_taken.
  - JUMP: seletor=010, pc_write=1.
  - JR: seletor=001, pc_write=1.
  - RTE: seletor=011, pc_write=1.
  - Reserved kinds: seletor=001, pc_write=0.
  - done=1 in every case.
- EXC entry, kind 101:
  - EXC_SAVE, one cycle: epc_write=1 (the datapath presents PC-4 on aluResult), mem_read=1, vec_addr=VEC_BASE+code. Reserved code 3 uses code 0.
  - EXC_WAIT: lasts MEM_LAT cycles. mem_read and vec_addr are held. A counter loads MEM_LAT-1 and leaves when it reaches 0.
  - EXC_LOAD, one cycle: seletor=100, pc_write=1, done=1. mem_read drops. Next state is IDLE.
- vec_addr is 32 bits, zero-extended, with no wrap: 253 + code ≤ 255.
- epc_write and pc_write are never high in the same cycle.

## Timing
- Reset values: state IDLE, seletor=001, pc_write=0, epc_write=0, mem_read=0, vec_addr=0, busy=0, done=0, req_ready=1. The wait counter resets to 0.
- All outputs are decoded from registered state and latched fields, with no combinational path from req_* inputs. req_ready is !busy.
- Non-exception request accepted at edge N:
  - EXEC is cycle N+1; the PC is written at edge N+2.
  - The next request can be accepted at edge N+2.
  - Throughput is one request per 2 cycles.
- EXC accepted at edge N:
  - EXC_SAVE is cycle N+1.
  - EXC_WAIT is cycles N+2 .. N+1+MEM_LAT.
  - EXC_LOAD is cycle N+2+MEM_LAT.
  - Total 2+MEM_LAT busy cycles; with MEM_LAT=1, done is high in cycle N+3.
- Reset asserted in any state, including mid-exception: the next edge returns to IDLE with reset values. A partial EPC save is not undone. No PC write occurs after reset.
- Edge-ordering cases:
  - req_valid in the same cycle as done is not accepted; req_ready is low.
  - A request arriving in the cycle after done is accepted.

## Structure
- Shared package pc_ctrl_pkg holds:
  - the state enum;
  - req_kind codes;
  - seletor codes, to keep the encoding consistent with the mux;
  - exception code constants and the VEC_BASE default.
- One sub-module, lat_counter: a 3-bit loadable down-counter with load, enable and zero flag, used for EXC_WAIT.

## Test plan
- Reset: hold reset 2 cycles with req_valid=1 and kind=SEQ -> all outputs at reset values, no pc_write; after release, SEQ is accepted and pc_write=1 with seletor=001 exactly one cycle later.
- BRANCH with branch_taken=0, then with branch_taken=1 -> seletor=000 both times; pc_write 0 then 1; done pulses each time; req_ready low exactly one cycle each.
- JUMP, JR, RTE back-to-back with req_valid held high -> seletor sequence 010, 001, 011 on alternate cycles; requests presented during EXEC are ignored.
- EXC with exc_code=1 and MEM_LAT=1 -> N+1: epc_write=1, mem_read=1, vec_addr=254; N+2: wait; N+3: seletor=100, pc_write=1, done=1. Repeat with MEM_LAT=3 -> done at N+5.
- EXC with exc_code=3 -> vec_addr=253. Reserved kind 110 -> done pulse with pc_write=0.
- Reset asserted during EXC_WAIT -> IDLE on the next edge, no pc_write, mem_read low; a following SEQ completes normally.
